program_loader: RTL and testbench
=================================

# program_loader

Byte-stream front end that fills the CPU's instruction memory: it receives a framed program over a valid/ready byte interface and drives the CPU's code-installation port (`clear_code`, `getcode`, `instruction_in`). It holds the CPU's `reset_n` low until a frame has loaded with a correct checksum. It sits between the host link (UART/byte bridge) and `Single_Circle_CPU`, as the writer side of the CPU's code-load interface.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clocks between bytes inside a frame.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  incoming byte.
- `rx_ready`  out  1  loader accepts a byte. A byte transfers when `rx_valid && rx_ready`.
- `clear_code`  out  1  one-cycle pulse that resets the CPU load pointer.
- `getcode`  out  1  one-cycle write strobe into CPU instruction memory.
- `instruction_out`  out  16  word written; connects to CPU `instruction_in`.
- `cpu_reset_n`  out  1  drives CPU `reset_n`; low = CPU held.
- `load_done`  out  1  sticky: last frame loaded and checksum matched.
- `load_error`  out  1  sticky: last frame failed (count 0, checksum, or timeout).

## Operation
- Frame format: `SYNC_BYTE`, count N (1..255 words), 2N data bytes (high byte first per word), checksum.
- Checksum = (N + sum of all data bytes) mod 256.
- All outputs are registered.
- FSM states:
  - IDLE: `rx_ready`=1. Bytes other than `SYNC_BYTE` are dropped. Sync → CLEAR; at the same time clear `load_done` and `load_error`, and drive `cpu_reset_n`=0.
  - CLEAR: `clear_code`=1 for one cycle, `rx_ready`=0 → COUNT.
  - COUNT: `rx_ready`=1. Accept N. If N=0 → ERROR. Otherwise load the word counter with N, seed the sum with N → HI.
  - HI: `rx_ready`=1. Latch the high byte and add it to the sum → LO.
  - LO: `rx_ready`=1. Latch the low byte and add it to the sum; present the assembled word on `instruction_out` → WRITE.
  - WRITE: `getcode`=1 for one cycle; decrement the word counter → GAP.
  - GAP: `getcode`=0 for one cycle (gives the CPU a strobe edge on every word). Then HI if words remain, else CHECK.
  - CHECK: `rx_ready`=1. Accept the checksum byte. Match → DONE; mismatch → ERROR.
  - DONE: set `load_done`=1 and `cpu_reset_n`=1 → IDLE.
  - ERROR: set `load_error`=1; `cpu_reset_n` stays 0 → IDLE.
- Timeout: a counter runs in COUNT/HI/LO/CHECK while no byte transfers and is cleared on every transfer. Reaching `TIMEOUT_CYCLES` → ERROR.
- `instruction_out` holds its last value outside WRITE.
- Never asserted simultaneously: `clear_code` and `getcode`; `getcode` and `rx_ready`.
- A sync byte arriving mid-frame is treated as data, not as a restart.

## Timing
- Reset values: `rx_ready`=0, `clear_code`=0, `getcode`=0, `instruction_out`=16'h0000, `cpu_reset_n`=0, `load_done`=0, `load_error`=0. FSM returns to IDLE, with `rx_ready`=1 on the first clock after reset deasserts.
- Reset mid-frame aborts the frame immediately. The CPU stays held.
- Sync accepted at cycle t:
  - `cpu_reset_n`=0 at t+1.
  - `clear_code` high during t+1 only.
  - `rx_ready` high again at t+2.
- Low byte accepted at t:
  - `getcode` high during t+1.
  - low at t+2.
  - `rx_ready` high at t+3.
- Checksum accepted at c: `load_done`/`load_error` and `cpu_reset_n` update at c+1. `rx_ready` is high at c+2.
- Throughput: at most 1 word per 4 cycles.

## Structure
- Shared package `loader_pkg`: FSM state enum, `SYNC_BYTE` default, and the checksum width constant.
- One natural sub-module: `byte_timeout`, a clearable saturating counter with a compare against `TIMEOUT_CYCLES`.
- Everything else is a single FSM in `program_loader`.

## Test plan
- Frame A5 01 12 34 47:
  - one `clear_code` pulse.
  - one `getcode` pulse with `instruction_out`=16'h1234.
  - `load_done`=1, `cpu_reset_n`=1, `load_error`=0.
- Frame A5 02 AB CD 00 01 7B (sum 0x7B):
  - two `getcode` pulses, carrying 16'hABCD then 16'h0001, separated by ≥1 low cycle.
  - `load_done`=1.
- Frame A5 01 12 34 00 (bad checksum):
  - `getcode` fires once.
  - `load_error`=1, `load_done`=0, `cpu_reset_n` stays 0.
- Bytes 00 FF 3C, then a valid frame: leading bytes are ignored (no `clear_code`), and the frame loads normally.
- Frame A5 00:
  - `load_error`=1 one cycle after the count byte.
  - no `getcode` pulse.
  - next valid frame succeeds.
- With `TIMEOUT_CYCLES`=16:
  - stall after the high byte for 16 cycles → `load_error`=1, FSM in IDLE.
  - separately, `reset` pulse mid-frame → all outputs at reset values, then a following good frame loads.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, default frame
// marker and the checksum accumulator width.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_GAP,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         CSUM_W       = 8;

  // States in which the loader is waiting on the host for a byte.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Clearable saturating idle counter; flags expiry on the idle cycle that
// completes TIMEOUT_CYCLES consecutive cycles without a byte transfer.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt < LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A transfer in the same cycle always wins over expiry.
  assign expired = enable && !clear && (cnt >= LIMIT);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that installs a program into the CPU instruction
// memory and releases the CPU from reset only after a checksum-clean frame.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        clear_code,
  output logic        getcode,
  output logic [15:0] instruction_out,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);

  state_t            state, state_nx;
  logic              xfer;
  logic              expired;
  logic              waiting;
  logic [7:0]        words;
  logic [7:0]        hi_byte;
  logic [CSUM_W-1:0] sum;

  logic              ready_nx, clear_nx, get_nx;
  logic              cpu_nx, done_nx, error_nx;

  assign xfer    = rx_valid && rx_ready;
  assign waiting = is_wait_state(state);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (xfer || !waiting),
    .enable (waiting),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Outputs are registered from the state being entered, so every strobe
  // and flag appears in the first cycle of its state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (xfer && (rx_data == SYNC_BYTE)) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_COUNT;
      S_COUNT: begin
        if (xfer)         state_nx = (rx_data == 8'h00) ? S_ERROR : S_HI;
        else if (expired) state_nx = S_ERROR;
      end
      S_HI: begin
        if (xfer)         state_nx = S_LO;
        else if (expired) state_nx = S_ERROR;
      end
      S_LO: begin
        if (xfer)         state_nx = S_WRITE;
        else if (expired) state_nx = S_ERROR;
      end
      S_WRITE: state_nx = S_GAP;
      S_GAP:   state_nx = (words == 8'h00) ? S_CHECK : S_HI;
      S_CHECK: begin
        if (xfer)         state_nx = (rx_data == sum) ? S_DONE : S_ERROR;
        else if (expired) state_nx = S_ERROR;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    ready_nx = (state_nx == S_IDLE) || is_wait_state(state_nx);
    clear_nx = (state_nx == S_CLEAR);
    get_nx   = (state_nx == S_WRITE);
    cpu_nx   = cpu_reset_n;
    done_nx  = load_done;
    error_nx = load_error;
    if (state_nx == S_CLEAR) begin
      cpu_nx   = 1'b0;
      done_nx  = 1'b0;
      error_nx = 1'b0;
    end else if (state_nx == S_DONE) begin
      cpu_nx  = 1'b1;
      done_nx = 1'b1;
    end else if (state_nx == S_ERROR) begin
      error_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready        <= 1'b0;
      clear_code      <= 1'b0;
      getcode         <= 1'b0;
      cpu_reset_n     <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
      instruction_out <= 16'h0000;
      words           <= 8'h00;
    end else begin
      rx_ready    <= ready_nx;
      clear_code  <= clear_nx;
      getcode     <= get_nx;
      cpu_reset_n <= cpu_nx;
      load_done   <= done_nx;
      load_error  <= error_nx;
      if (state_nx == S_WRITE) begin
        instruction_out <= {hi_byte, rx_data};
      end
      if ((state == S_COUNT) && xfer) begin
        words <= rx_data;
      end else if (state == S_WRITE) begin
        words <= words - 8'h01;
      end
    end
  end

  // Running checksum is seeded with the count and wraps modulo 2^CSUM_W.
  always_ff @(posedge clk) begin
    if ((state == S_COUNT) && xfer) begin
      sum <= rx_data;
    end else if (((state == S_HI) || (state == S_LO)) && xfer) begin
      sum <= sum + rx_data;
    end
    if ((state == S_HI) && xfer) begin
      hi_byte <= rx_data;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a frame-level reference model predicts
// every output each cycle, with literal pins on the documented scenarios.
module tb_program_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        clear_code;
  logic        getcode;
  logic [15:0] instruction_out;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  program_loader #(
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .clear_code     (clear_code),
    .getcode        (getcode),
    .instruction_out(instruction_out),
    .cpu_reset_n    (cpu_reset_n),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks frame position and a ready-blackout count.
  logic        m_ready, m_clear, m_get, m_cpu, m_done, m_err;
  logic [15:0] m_instr;
  bit          m_inframe;
  int          m_pos, m_n, m_sum, m_idle, m_black;
  logic [7:0]  m_hi;

  task automatic model_reset();
    m_ready = 0; m_clear = 0; m_get = 0; m_cpu = 0; m_done = 0; m_err = 0;
    m_instr = 16'h0000; m_inframe = 0; m_pos = 0; m_n = 0; m_sum = 0;
    m_idle = 0; m_black = 1; m_hi = 8'h00;
  endtask

  task automatic model_abort_error();
    m_err = 1; m_inframe = 0; m_ready = 0; m_black = 1; m_idle = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    bit xfer;
    xfer = v && m_ready;
    m_clear = 0;
    m_get = 0;
    if (m_black > 0) begin
      m_black--;
      if (m_black == 0) m_ready = 1;
    end else if (xfer) begin
      m_idle = 0;
      if (!m_inframe) begin
        if (d == SYNC) begin
          m_inframe = 1; m_pos = 0; m_clear = 1;
          m_cpu = 0; m_done = 0; m_err = 0; m_ready = 0; m_black = 1;
        end
      end else if (m_pos == 0) begin
        if (d == 8'h00) model_abort_error();
        else begin m_n = d; m_sum = d; m_pos = 1; end
      end else if (m_pos <= 2 * m_n) begin
        m_sum += d;
        if (m_pos % 2 == 1) m_hi = d;
        else begin m_instr = {m_hi, d}; m_get = 1; m_ready = 0; m_black = 2; end
        m_pos++;
      end else begin
        if (d == 8'(m_sum & 255)) begin m_done = 1; m_cpu = 1; end
        else m_err = 1;
        m_inframe = 0; m_ready = 0; m_black = 1;
      end
    end else if (m_inframe && m_ready) begin
      m_idle++;
      if (m_idle == TO) model_abort_error();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step(rx_valid, rx_data);
    end
  end

  // Per-cycle comparison plus pulse bookkeeping for the literal pins.
  int          n_clear = 0;
  int          n_get   = 0;
  logic [15:0] got_words[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("rx_ready", 16'(rx_ready), 16'(m_ready));
      chk("clear_code", 16'(clear_code), 16'(m_clear));
      chk("getcode", 16'(getcode), 16'(m_get));
      chk("instruction_out", instruction_out, m_instr);
      chk("cpu_reset_n", 16'(cpu_reset_n), 16'(m_cpu));
      chk("load_done", 16'(load_done), 16'(m_done));
      chk("load_error", 16'(load_error), 16'(m_err));
      chk("strobe_overlap", 16'((clear_code && getcode) || (getcode && rx_ready)), 16'h0);
      if (clear_code) n_clear++;
      if (getcode) begin n_get++; got_words.push_back(instruction_out); end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 40; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake byte=%h not accepted within 40 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    foreach (f[i]) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send_byte(f[i]);
    end
    idle(4);
  endtask

  task automatic reset_counts();
    n_clear = 0;
    n_get   = 0;
    got_words.delete();
  endtask

  task automatic expect_result(input string tag, input bit good, input int gets);
    chk({tag, "_done"}, 16'(load_done), 16'(good));
    chk({tag, "_error"}, 16'(load_error), 16'(!good));
    chk({tag, "_cpu"}, 16'(cpu_reset_n), 16'(good));
    chk({tag, "_gets"}, 16'(n_get), 16'(gets));
    chk({tag, "_model_done"}, 16'(m_done), 16'(good));
  endtask

  logic [7:0] fr[$];

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 16'(rx_ready), 16'h0);
    chk("rst_cpu", 16'(cpu_reset_n), 16'h0);
    chk("rst_instr", instruction_out, 16'h0000);
    reset = 1'b0;
    idle(2);
    chk("idle_ready", 16'(rx_ready), 16'h1);

    // Single word frame.
    reset_counts();
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
    send_frame(fr, 0);
    expect_result("one_word", 1, 1);
    chk("one_word_clear", 16'(n_clear), 16'd1);
    chk("one_word_data", got_words[0], 16'h1234);

    // Two words, checksum wraps.
    reset_counts();
    fr = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h7B};
    send_frame(fr, 1);
    expect_result("two_word", 1, 2);
    chk("two_word_w0", got_words[0], 16'hABCD);
    chk("two_word_w1", got_words[1], 16'h0001);

    // Bad checksum.
    reset_counts();
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
    send_frame(fr, 0);
    expect_result("bad_sum", 0, 1);

    // Leading junk is dropped.
    reset_counts();
    fr = '{8'h00, 8'hFF, 8'h3C};
    send_frame(fr, 0);
    chk("junk_clear", 16'(n_clear), 16'd0);
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
    send_frame(fr, 0);
    expect_result("after_junk", 1, 1);

    // Zero count.
    reset_counts();
    fr = '{8'hA5, 8'h00};
    send_frame(fr, 0);
    expect_result("zero_count", 0, 0);
    reset_counts();
    fr = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'hAE};
    send_frame(fr, 2);
    expect_result("after_zero", 1, 1);
    chk("after_zero_data", got_words[0], 16'hBEEF);

    // Stall after the high byte.
    reset_counts();
    fr = '{8'hA5, 8'h01, 8'h12};
    send_frame(fr, 0);
    idle(TO + 4);
    expect_result("timeout", 0, 0);
    chk("timeout_ready", 16'(rx_ready), 16'h1);
    reset_counts();
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
    send_frame(fr, 0);
    expect_result("after_timeout", 1, 1);

    // Reset mid-frame.
    fr = '{8'hA5, 8'h02, 8'h11};
    send_frame(fr, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", 16'(rx_ready), 16'h0);
    chk("midrst_cpu", 16'(cpu_reset_n), 16'h0);
    chk("midrst_done", 16'(load_done), 16'h0);
    chk("midrst_instr", instruction_out, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reset_counts();
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
    send_frame(fr, 1);
    expect_result("after_reset", 1, 1);

    // Randomized frames, some corrupted, some preceded by junk.
    for (int k = 0; k < 25; k++) begin
      int         n;
      int         s;
      bit         good;
      logic [7:0] b;
      reset_counts();
      fr.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        fr.push_back(b);
      end
      n = $urandom_range(1, 6);
      fr.push_back(SYNC);
      fr.push_back(8'(n));
      s = n;
      for (int j = 0; j < 2 * n; j++) begin
        b = 8'($urandom);
        fr.push_back(b);
        s += b;
      end
      good = ($urandom_range(0, 3) != 0);
      fr.push_back(good ? 8'(s) : (8'(s) ^ 8'h5A));
      send_frame(fr, 3);
      expect_result("random", good, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
